// File: rtl/rr_grant_index.sv
// Round-robin arbiter over 8 requesters. Emits a registered grant index and valid
// flag, and holds each grant until release, request drop, or MAX_HOLD expiry.
module rr_grant_index #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_cnt_q;
  logic       grant_valid_q;
  logic [2:0] grant_idx_q;
  logic       timeout_q;

  logic       sel_found_d;
  logic [2:0] sel_idx_d;
  logic [2:0] cand;

  // Walk from the farthest offset back to ptr so the nearest set bit wins.
  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = ptr_q;
    cand        = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr_q + 3'(k);
      if (req[cand]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd0;
      hold_cnt_q    <= 8'd0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 3'd0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_found_d) begin
            grant_idx_q   <= sel_idx_d;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= 8'd0;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (release_i || !req[grant_idx_q] || hold_cnt_q == HOLD_LAST) begin
            // Release or request drop outranks expiry, so only a pure expiry pulses.
            timeout_q     <= !(release_i || !req[grant_idx_q]);
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= 8'd0;
            ptr_q         <= grant_idx_q + 3'd1;
            state_q       <= IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_index.sv
// Scoreboard bench for rr_grant_index: stimulus queues each expected grant
// (index, length, timeout), a negedge monitor checks every completed grant.
module tb_rr_grant_index;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       release_i;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       timeout_o;

  rr_grant_index #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .release_i  (release_i),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rel);
    req       = r;
    release_i = rel;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [2:0] idx, input int len, input logic tmo);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.tmo = tmo;
    sbq.push_back(e);
  endtask

  // Monitor: tracks each valid window and scores it when grant_valid falls.
  initial begin
    logic       prev_v = 1'b0;
    logic       after_fall = 1'b0;
    logic [2:0] cap_idx = 3'd0;
    int         len = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (after_fall) chk("timeout_one_cycle", 32'(timeout_o), 32'd0);
      after_fall = 1'b0;
      if (grant_valid === 1'b1 && !prev_v) begin
        cap_idx = grant_idx;
        len     = 1;
      end else if (grant_valid === 1'b1) begin
        len++;
        chk("idx_stable", 32'(grant_idx), 32'(cap_idx));
      end else if (prev_v) begin
        after_fall = 1'b1;
        if (sbq.size() == 0) begin
          chk("unexpected_grant", 32'(cap_idx), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("grant_idx", 32'(cap_idx), 32'(e.idx));
          chk("grant_len", 32'(len), 32'(e.len));
          chk("timeout_at_end", 32'(timeout_o), 32'(e.tmo));
        end
      end
      prev_v = (grant_valid === 1'b1);
    end
  end

  initial begin
    int budget;
    rst_n = 1'b0; req = 8'hFF; release_i = 1'b0;

    // Reset with all requests pending
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    rst_n = 1'b1;
    expect_grant(3'd0, 1, 1'b0);
    step(8'hFF, 1'b0);
    chk("first_idx", 32'(grant_idx), 32'd0);
    chk("first_valid", 32'(grant_valid), 32'd1);
    step(8'hFF, 1'b1);

    // Single requester, release then regrant after one idle cycle
    expect_grant(3'd3, 1, 1'b0);
    expect_grant(3'd3, 1, 1'b0);
    step(8'h08, 1'b0);
    step(8'h08, 1'b1);
    chk("gap_low", 32'(grant_valid), 32'd0);
    step(8'h08, 1'b0);
    chk("regrant_valid", 32'(grant_valid), 32'd1);
    step(8'h08, 1'b1);

    // Fairness from ptr=0: 0..7 then wrap to 0
    rst_n = 1'b0;
    step(8'h00, 1'b0);
    rst_n = 1'b1;
    for (int g = 0; g < 9; g++) begin
      expect_grant(3'(g % 8), 2, 1'b0);
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
    end

    // Wrap and skip: 6, then 0 (wrap), then 5 ended by request drop
    expect_grant(3'd6, 1, 1'b0);
    expect_grant(3'd0, 1, 1'b0);
    expect_grant(3'd5, 1, 1'b0);
    step(8'h40, 1'b0);
    step(8'h40, 1'b1);
    step(8'h21, 1'b0);
    step(8'h21, 1'b1);
    step(8'h21, 1'b0);
    step(8'h01, 1'b0);

    // Timeout at MAX_HOLD=4; other req bits toggling must not matter
    expect_grant(3'd2, 4, 1'b1);
    step(8'h04, 1'b0);
    step(8'h84, 1'b0);
    step(8'h04, 1'b0);
    step(8'h0C, 1'b0);
    step(8'h04, 1'b0);
    chk("timeout_pulse", 32'(timeout_o), 32'd1);
    step(8'h00, 1'b0);

    // Release on the expiry cycle wins: no timeout
    expect_grant(3'd2, 4, 1'b0);
    step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    chk("release_beats_timeout", 32'(timeout_o), 32'd0);
    step(8'h00, 1'b0);

    // Mid-grant reset with hold_cnt=2, then ptr restarts at 0
    expect_grant(3'd5, 3, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    step(8'h20, 1'b0);
    rst_n = 1'b0;
    step(8'h22, 1'b0);
    chk("midrst_valid", 32'(grant_valid), 32'd0);
    chk("midrst_timeout", 32'(timeout_o), 32'd0);
    rst_n = 1'b1;
    expect_grant(3'd1, 1, 1'b0);
    step(8'h22, 1'b0);
    chk("post_rst_idx", 32'(grant_idx), 32'd1);
    step(8'h22, 1'b1);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    budget = 20;
    while (sbq.size() != 0 && budget > 0) begin
      step(8'h00, 1'b0);
      budget--;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
